fp16_norm_round: RTL

Post-add normalize/round stage of the half-precision (1/5/10) adder datapath. It sits directly downstream of the mantissa add/subtract stage and consumes its raw 11-bit mantissa, carry and round-sticky bit. It also takes the larger operand's exponent and the result sign. It normalizes iteratively (one bit per cycle), rounds, and packs a 16-bit IEEE754 binary16 result with status flags behind a valid/ready handshake.

---
 rtl/fp16_norm_round.sv | 106 ++++++++++
 1 files changed

// File: rtl/fp16_norm_round.sv
// fp16_norm_round: iterative normalize, round-to-nearest-even and pack stage of the binary16 adder.
module fp16_norm_round #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MAN_W:0]         rm_in,
    input  logic                   carry_in,
    input  logic                   sticky_in,
    input  logic                   eff_sub,
    input  logic [EXP_W-1:0]       exp_in,
    input  logic                   sign_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   flag_ovf,
    output logic                   flag_unf,
    output logic                   flag_inexact,
    output logic                   flag_zero
);
    localparam int EW = EXP_W + 1;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

    state_t                state, state_n;
    logic [MAN_W:0]        m;
    logic [EW-1:0]         e;
    logic                  s, zp, sg;
    logic                  norm_done;
    logic [MAN_W+1:0]      mr;
    logic [MAN_W:0]        mf;
    logic [EW-1:0]         ef;
    logic                  ovf;
    logic [EXP_W-1:0]      ex;
    logic [EXP_W+MAN_W:0]  res_n;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? NORM : IDLE;
            NORM:    state_n = norm_done ? ROUND : NORM;
            ROUND:   state_n = OUT;
            default: state_n = out_ready ? IDLE : OUT;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == OUT;
    end

    // Shifting stops at e==1 so a too-small result lands as a subnormal.
    assign norm_done = zp || m[MAN_W] || e <= EW'(1);

    // s acts as an exact-half guard, so ties go to the even mantissa.
    always_comb begin
        mr    = {1'b0, m} + (MAN_W+2)'(s & m[0]);
        mf    = mr[MAN_W+1] ? mr[MAN_W+1:1] : mr[MAN_W:0];
        ef    = e + EW'(mr[MAN_W+1]);
        ovf   = ef >= EW'((1 << EXP_W) - 1);
        ex    = mf[MAN_W] ? ef[EXP_W-1:0] : '0;
        res_n = ovf ? {sg, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                zp  ? {sg, {(EXP_W+MAN_W){1'b0}}} :
                      {sg, ex, mf[MAN_W-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m            <= '0;
            e            <= '0;
            s            <= 1'b0;
            zp           <= 1'b0;
            sg           <= 1'b0;
            result       <= '0;
            flag_ovf     <= 1'b0;
            flag_unf     <= 1'b0;
            flag_inexact <= 1'b0;
            flag_zero    <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                m  <= rm_in;
                e  <= {1'b0, exp_in} + EW'(carry_in && !eff_sub);
                s  <= sticky_in;
                zp <= rm_in == '0;
                sg <= (rm_in == '0 && eff_sub) ? 1'b0 : sign_in;
            end
            if (state == NORM && !norm_done) begin
                m <= m << 1;
                e <= e - EW'(1);
            end
            if (state == ROUND) begin
                result       <= res_n;
                flag_ovf     <= ovf;
                flag_unf     <= !ovf && !zp && ex == '0;
                flag_inexact <= s || ovf;
                flag_zero    <= !ovf && zp;
            end
        end
endmodule
